// File: rtl/primitives_pkg.sv
// rtl/primitives_pkg.sv - shared geometry types for the graphics engine
// Purpose: Q8.8 vertex, normal, face and matrix types plus the face
//          transform FSM state encoding.
// Ports:   none (package).
package Primitives;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex_t;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] j;
    logic [15:0] k;
  } Normal_t;

  typedef struct packed {
    Vertex_t     v1;
    Vertex_t     v2;
    Vertex_t     v3;
    Normal_t     normal;
    logic [11:0] color;
  } Face_t;

  // Columns v1/v2/v3 produce the output x/y/z components respectively.
  typedef struct packed {
    Vertex_t v1;
    Vertex_t v2;
    Vertex_t v3;
  } Matrix_t;

  localparam int FACES_BITS  = $bits(Face_t);
  localparam int MATRIX_BITS = $bits(Matrix_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFORM = 2'd1,
    DONE  = 2'd2
  } XformState_t;

endpackage

// File: rtl/dot_product.sv
// rtl/dot_product.sv - combinational Q8.8 three-term dot product
// Purpose: result = a.x*b.x + a.y*b.y + a.z*b.z in Q8.8.
// Ports:   a, b   - Q8.8 operand vectors
//          result - Q8.8 sum, wraps modulo 2^16
module DotProduct
  import Primitives::*;
(
  input  Vertex_t     a,
  input  Vertex_t     b,
  output logic [15:0] result
);

  // Multiply on magnitudes so truncation is toward zero for both signs,
  // then restore the sign. A magnitude of 0x8000 is still correct when
  // read as unsigned.
  function automatic logic [15:0] mul_q88(input logic [15:0] p, input logic [15:0] q);
    logic [15:0] mag_p;
    logic [15:0] mag_q;
    logic [31:0] prod;
    logic [15:0] trunc;
    mag_p = p[15] ? (~p + 16'd1) : p;
    mag_q = q[15] ? (~q + 16'd1) : q;
    prod  = {16'd0, mag_p} * {16'd0, mag_q};
    trunc = 16'(prod >> 8);
    return (p[15] ^ q[15]) ? (~trunc + 16'd1) : trunc;
  endfunction

  assign result = mul_q88(a.x, b.x) + mul_q88(a.y, b.y) + mul_q88(a.z, b.z);

endmodule

// File: rtl/face_transform.sv
// rtl/face_transform.sv - per-face matrix transform stage
// Purpose: latches a face and matrix, transforms v1, v2, v3 and the normal
//          one element per cycle over three DotProduct units, then holds
//          the result until downstream accepts it.
// Ports:   clk, rst_n            - clock, async active-low reset
//          in_valid/in_ready     - input handshake (ready only in IDLE)
//          in_face, in_matrix    - face and transform to apply
//          out_valid/out_ready   - output handshake
//          out_face              - transformed face, registered
//          face_count            - faces delivered since reset, wrapping
module face_transform
  import Primitives::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FACES_BITS-1:0]  in_face,
  input  logic [MATRIX_BITS-1:0] in_matrix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FACES_BITS-1:0]  out_face,
  output logic [15:0]            face_count
);

  XformState_t state;
  XformState_t state_nxt;
  logic [1:0]  idx;
  Face_t       face_q;
  Matrix_t     mat_q;
  Face_t       out_q;
  Vertex_t     point;
  logic [15:0] x_res;
  logic [15:0] y_res;
  logic [15:0] z_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = XFORM;
      end
      XFORM: begin
        // The normal is element 3; writing it completes the face.
        if (idx == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Normal i/j/k are fed through the same path as a vertex's x/y/z.
  always_comb begin
    point = '0;
    unique case (idx)
      2'd0:    point = face_q.v1;
      2'd1:    point = face_q.v2;
      2'd2:    point = face_q.v3;
      default: point = {face_q.normal.i, face_q.normal.j, face_q.normal.k};
    endcase
  end

  DotProduct u_dot_x (.a(point), .b(mat_q.v1), .result(x_res));
  DotProduct u_dot_y (.a(point), .b(mat_q.v2), .result(y_res));
  DotProduct u_dot_z (.a(point), .b(mat_q.v3), .result(z_res));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      face_q     <= '0;
      mat_q      <= '0;
      out_q      <= '0;
      face_count <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            face_q <= in_face;
            mat_q  <= in_matrix;
            idx    <= 2'd0;
          end
        end
        XFORM: begin
          unique case (idx)
            2'd0:    out_q.v1     <= {x_res, y_res, z_res};
            2'd1:    out_q.v2     <= {x_res, y_res, z_res};
            2'd2:    out_q.v3     <= {x_res, y_res, z_res};
            default: out_q.normal <= {x_res, y_res, z_res};
          endcase
          out_q.color <= face_q.color;
          // Wraps 3 -> 0 on the last element, leaving idx ready for the next face.
          idx <= idx + 2'd1;
        end
        DONE: begin
          if (out_ready) face_count <= face_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_face = out_q;

endmodule

// File: tb/tb_face_transform.sv
// tb/tb_face_transform.sv - directed self-checking bench for face_transform
module tb_face_transform;
  import Primitives::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  Face_t       in_face = '0;
  Matrix_t     in_matrix = '0;
  Face_t       out_face;
  logic [15:0] face_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  face_transform dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_face    (in_face),
    .in_matrix  (in_matrix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_face   (out_face),
    .face_count (face_count)
  );

  function automatic Vertex_t vtx(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {x, y, z};
  endfunction

  function automatic Face_t mk_face(input Vertex_t a, input Vertex_t b, input Vertex_t c,
                                    input Vertex_t n, input logic [11:0] col);
    Face_t f;
    f.v1 = a;
    f.v2 = b;
    f.v3 = c;
    f.normal = {n.x, n.y, n.z};
    f.color = col;
    return f;
  endfunction

  function automatic Matrix_t mk_mat(input Vertex_t c1, input Vertex_t c2, input Vertex_t c3);
    Matrix_t m;
    m.v1 = c1;
    m.v2 = c2;
    m.v3 = c3;
    return m;
  endfunction

  Matrix_t m_id;
  Matrix_t m_scale;
  Matrix_t m_dbl;
  Face_t   f_id;

  // Entered and left on a falling edge. Accepts one face, scrambles the
  // inputs afterwards, and counts rising edges until out_valid (bounded).
  task automatic do_face(input Face_t f, input Matrix_t m, output int lat, output Face_t got);
    in_face   = f;
    in_matrix = m;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_face   = ~f;
    in_matrix = ~m;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = out_face;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_face !== '0) begin miscompares++; $display("FAIL reset_out_face: got %h want 0", out_face); end
    vectors++; if (face_count !== 16'd0) begin miscompares++; $display("FAIL reset_face_count: got %h want 0", face_count); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_identity();
    int lat;
    Face_t got;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ident_ready_before: got %b want 1", in_ready); end
    do_face(f_id, m_id, lat, got);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL ident_latency: got %0d want 4", lat); end
    vectors++; if (got !== f_id) begin miscompares++; $display("FAIL ident_face: got %h want %h", got, f_id); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ident_ready_in_done: got %b want 0", in_ready); end
    handshake();
    vectors++; if (face_count !== 16'd1) begin miscompares++; $display("FAIL ident_count: got %h want 1", face_count); end
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL ident_after_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_scale_sign();
    int lat;
    Face_t got;
    Face_t f;
    f = mk_face(vtx(16'h0180, 16'hFF00, 16'h0001), vtx(16'h0001, 16'hFFFF, 16'h0000),
                vtx(16'hFFFF, 16'h0003, 16'h0200), vtx(16'h0100, 16'h0100, 16'hFF00), 12'h123);
    do_face(f, m_scale, lat, got);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL scale_latency: got %0d want 4", lat); end
    vectors++; if (got.v1 !== vtx(16'h0300, 16'hFF80, 16'h0001)) begin miscompares++; $display("FAIL scale_v1: got %h want 0300ff800001", got.v1); end
    vectors++; if (got.v2 !== vtx(16'h0002, 16'h0000, 16'h0000)) begin miscompares++; $display("FAIL scale_v2_trunc: got %h want 000200000000", got.v2); end
    vectors++; if (got.v3 !== vtx(16'hFFFE, 16'h0001, 16'h0200)) begin miscompares++; $display("FAIL scale_v3: got %h want fffe00010200", got.v3); end
    vectors++; if (got.normal !== {16'h0200, 16'h0080, 16'hFF00}) begin miscompares++; $display("FAIL scale_normal: got %h want 02000080ff00", got.normal); end
    vectors++; if (got.color !== 12'h123) begin miscompares++; $display("FAIL scale_color: got %h want 123", got.color); end
    handshake();
    vectors++; if (face_count !== 16'd2) begin miscompares++; $display("FAIL scale_count: got %h want 2", face_count); end
  endtask

  task automatic test_overflow();
    int lat;
    Face_t got;
    Face_t f;
    f = mk_face(vtx(16'h7F00, 16'h4000, 16'hC000), vtx(16'h0, 16'h0, 16'h0),
                vtx(16'h0, 16'h0, 16'h0), vtx(16'h0, 16'h0, 16'h0), 12'h000);
    do_face(f, m_dbl, lat, got);
    vectors++; if (got.v1.x !== 16'hFE00) begin miscompares++; $display("FAIL ovf_x: got %h want fe00", got.v1.x); end
    vectors++; if (got.v1.y !== 16'h8000 || got.v1.z !== 16'h8000) begin miscompares++; $display("FAIL ovf_yz: got %h %h want 8000 8000", got.v1.y, got.v1.z); end
    handshake();
    vectors++; if (face_count !== 16'd3) begin miscompares++; $display("FAIL ovf_count: got %h want 3", face_count); end
  endtask

  task automatic test_backpressure();
    int lat;
    Face_t got;
    Face_t f;
    Face_t exp_f;
    f = mk_face(vtx(16'h0180, 16'hFF00, 16'h0001), vtx(16'h0001, 16'hFFFF, 16'h0000),
                vtx(16'h0000, 16'h0000, 16'h0000), vtx(16'h0000, 16'h0000, 16'h0100), 12'h5A5);
    exp_f = mk_face(vtx(16'h0300, 16'hFF80, 16'h0001), vtx(16'h0002, 16'h0000, 16'h0000),
                    vtx(16'h0000, 16'h0000, 16'h0000), vtx(16'h0000, 16'h0000, 16'h0100), 12'h5A5);
    do_face(f, m_scale, lat, got);
    for (int i = 0; i < 10; i++) begin
      in_face  = mk_face(vtx(16'(i), 16'h1111, 16'h2222), vtx(16'h3, 16'h4, 16'h5),
                         vtx(16'h6, 16'h7, 16'h8), vtx(16'h9, 16'hA, 16'hB), 12'hFFF);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      vectors++; if (out_face !== exp_f) begin miscompares++; $display("FAIL bp_face[%0d]: got %h want %h", i, out_face, exp_f); end
    end
    in_valid = 1'b0;
    handshake();
    vectors++; if (face_count !== 16'd4) begin miscompares++; $display("FAIL bp_count: got %h want 4", face_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_single_hs: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    Face_t b[3];
    Face_t outs[3];
    int acc_cyc[3];
    int n_acc = 0;
    int n_out = 0;
    int cyc = 0;
    b[0] = mk_face(vtx(16'h0001, 16'h0002, 16'h0003), vtx(16'h0004, 16'h0005, 16'h0006),
                   vtx(16'h0007, 16'h0008, 16'h0009), vtx(16'h000A, 16'h000B, 16'h000C), 12'h111);
    b[1] = mk_face(vtx(16'hFFFF, 16'h0100, 16'hFE00), vtx(16'h7FFF, 16'h8000, 16'h0010),
                   vtx(16'h0020, 16'h0030, 16'h0040), vtx(16'h0000, 16'h0100, 16'h0000), 12'h222);
    b[2] = mk_face(vtx(16'h1234, 16'h5678, 16'h0ABC), vtx(16'hEDCC, 16'h0001, 16'h0002),
                   vtx(16'h0003, 16'h0004, 16'h0005), vtx(16'hFF00, 16'h0000, 16'h0000), 12'h333);
    for (int i = 0; i < 3; i++) begin
      outs[i] = '0;
      acc_cyc[i] = 0;
    end
    in_matrix = m_id;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while ((n_acc < 3 || n_out < 3) && cyc < 100) begin
      if (out_valid && n_out < 3) begin
        outs[n_out] = out_face;
        n_out++;
      end
      if (in_ready) begin
        if (n_acc < 3) begin
          in_face = b[n_acc];
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (n_acc !== 3 || n_out !== 3) begin miscompares++; $display("FAIL b2b_counts: got acc=%0d out=%0d want 3/3", n_acc, n_out); end
    vectors++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin miscompares++; $display("FAIL b2b_gap01: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
    vectors++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin miscompares++; $display("FAIL b2b_gap12: got %0d want 6", acc_cyc[2] - acc_cyc[1]); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (outs[i] !== b[i]) begin miscompares++; $display("FAIL b2b_face[%0d]: got %h want %h", i, outs[i], b[i]); end
    end
    vectors++; if (face_count !== 16'd7) begin miscompares++; $display("FAIL b2b_count: got %h want 7", face_count); end
  endtask

  task automatic test_reset_mid();
    int lat;
    Face_t got;
    in_face   = mk_face(vtx(16'h0180, 16'hFF00, 16'h0001), vtx(16'h0001, 16'hFFFF, 16'h0000),
                        vtx(16'h0100, 16'h0100, 16'h0100), vtx(16'h0100, 16'h0100, 16'h0100), 12'h777);
    in_matrix = m_scale;
    in_valid  = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    vectors++; if (out_face !== '0) begin miscompares++; $display("FAIL rmid_face: got %h want 0", out_face); end
    vectors++; if (face_count !== 16'd0) begin miscompares++; $display("FAIL rmid_count: got %h want 0", face_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    do_face(f_id, m_id, lat, got);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rmid_next_latency: got %0d want 4", lat); end
    vectors++; if (got !== f_id) begin miscompares++; $display("FAIL rmid_next_face: got %h want %h", got, f_id); end
    handshake();
    vectors++; if (face_count !== 16'd1) begin miscompares++; $display("FAIL rmid_next_count: got %h want 1", face_count); end
  endtask

  initial begin
    m_id    = mk_mat(vtx(16'h0100, 16'h0, 16'h0), vtx(16'h0, 16'h0100, 16'h0), vtx(16'h0, 16'h0, 16'h0100));
    m_scale = mk_mat(vtx(16'h0200, 16'h0, 16'h0), vtx(16'h0, 16'h0080, 16'h0), vtx(16'h0, 16'h0, 16'h0100));
    m_dbl   = mk_mat(vtx(16'h0200, 16'h0, 16'h0), vtx(16'h0, 16'h0200, 16'h0), vtx(16'h0, 16'h0, 16'h0200));
    f_id    = mk_face(vtx(16'h0180, 16'hFF00, 16'h0040), vtx(16'h8000, 16'h7FFF, 16'h0001),
                      vtx(16'h1234, 16'hEDCC, 16'h0000), vtx(16'h0000, 16'h0000, 16'h0100), 12'hABC);
    @(negedge clk);
    test_reset();
    test_identity();
    test_scale_sign();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
